// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default line timing, FSM states and
// the clocks-per-bit helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS     = 8;
  localparam int DEF_CLK_FREQ  = 27000000;
  localparam int DEF_BAUD_RATE = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; RST_VAL sets the
// value both flops take in reset (idle level of the line being sampled).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ready output and framing /
// overrun pulses. Define UART_RX_PARITY_EN to add a parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE,
`ifdef UART_RX_PARITY_EN
  parameter bit PARITY_ODD  = 1'b0,
`endif
  parameter int BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUD_RATE),
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  state_t                 state_reg;
  logic [CNT_W-1:0]       baud_cnt_reg;
  logic [IDX_W-1:0]       bit_idx_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   rx_sync;
  logic                   rx_prev_reg;
  logic                   drop_byte;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_sync)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg;
  assign drop_byte = par_bad_reg;
`else
  assign drop_byte = 1'b0;
`endif

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rx_prev_reg  <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg  <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_prev_reg <= rx_sync;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (rx_prev_reg && !rx_sync)
            state_reg <= START;
        end

        // Re-check the line at mid start bit to reject short glitches.
        START: begin
          if (baud_cnt_reg == HALF_LAST) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg           <= '0;
            shift_reg[bit_idx_reg] <= rx_sync;
            if (bit_idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            par_bad_reg  <= ((^shift_reg) ^ rx_sync) != PARITY_ODD;
            parity_err   <= ((^shift_reg) ^ rx_sync) != PARITY_ODD;
            state_reg    <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
`endif

        // A completing byte overwrites any unaccepted one; same-cycle accept is not an overrun.
        STOP: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            if (rx_sync) begin
              state_reg <= IDLE;
              if (!drop_byte) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
              end
            end else begin
              frame_err <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        WAIT_HIGH: begin
          baud_cnt_reg <= '0;
          if (rx_sync)
            state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at a shortened bit time (16 clocks/bit);
// frames are built from bit lists and outcomes predicted from frame rules.
module tb_uart_rx;

  localparam int CLK_F = 160000;
  localparam int BAUD  = 10000;
  localparam int BIT   = CLK_F / BAUD;
  localparam int HALF  = BIT / 2;
  localparam bit PODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR  = 1;
`else
  localparam int NPAR  = 0;
`endif
  localparam int LAT   = HALF + (9 + NPAR) * BIT + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int got_n = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .CLK_FREQ   (CLK_F),
`ifdef UART_RX_PARITY_EN
    .PARITY_ODD (PODD),
`endif
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  // Monitor: counts pulses and logs every accepted byte.
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
    if (rx_valid && rx_ready) begin
      got_mem[got_n[7:0]] <= rx_data;
      got_n <= got_n + 1;
      $display("cycle %0d: accepted byte %02h", cyc, rx_data);
    end
  end

  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level; caller decides what follows.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (NPAR != 0) drive_bit(pbit);
    drive_bit(stop_b);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst = 1'b0;
    idle(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int n0, fe0, ov0, start, lat;
    rx_ready = 1'b1;
    n0 = got_n; fe0 = fe_cnt; ov0 = ov_cnt;
    start = cyc;
    send_frame(8'h55, 1'b1, par_of(8'h55));
    lat = rise_cyc - start;
    total++; if (got_n - n0 !== 1 || lat < LAT - 1 || lat > LAT + 1) begin
      bad++; $display("FAIL basic_latency: got %0d clocks (bytes %0d) want %0d+-1", lat, got_n - n0, LAT);
    end
    send_frame(8'hA5, 1'b1, par_of(8'hA5));
    idle(BIT);
    total++; if (got_n - n0 !== 2) begin bad++; $display("FAIL basic_count: got %0d want 2", got_n - n0); end
    total++; if (got_mem[n0[7:0]] !== 8'h55) begin bad++; $display("FAIL basic_byte0: got %h want 55", got_mem[n0[7:0]]); end
    total++; if (got_mem[8'(n0 + 1)] !== 8'hA5) begin bad++; $display("FAIL basic_byte1: got %h want a5", got_mem[8'(n0 + 1)]); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt - fe0); end
    total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL basic_overrun: got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch;
    int n0;
    n0 = got_n;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (HALF + 4 - 5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    idle(2 * BIT);
    total++; if (got_n !== n0) begin bad++; $display("FAIL glitch_no_byte: got %0d bytes want 0", got_n - n0); end
  endtask

  task automatic test_frame_err;
    int n0, fe0;
    n0 = got_n; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, par_of(8'h3C));
    drive_bit(1'b0);
    drive_bit(1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_wait_high_busy: got %b want 1", busy); end
    idle(BIT);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    total++; if (got_n !== n0 || rx_valid !== 1'b0) begin bad++; $display("FAIL ferr_no_byte: got %0d bytes valid=%b want 0/0", got_n - n0, rx_valid); end
    send_frame(8'h81, 1'b1, par_of(8'h81));
    idle(BIT);
    total++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h81) begin
      bad++; $display("FAIL ferr_next_frame: got %0d bytes first=%h want 1 byte 81", got_n - n0, got_mem[n0[7:0]]);
    end
  endtask

  task automatic test_overrun;
    int n0, ov0;
    rx_ready = 1'b0;
    n0 = got_n; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, par_of(8'h11));
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin bad++; $display("FAIL ovr_first: got valid=%b data=%h want 1/11", rx_valid, rx_data); end
    send_frame(8'h22, 1'b1, par_of(8'h22));
    idle(BIT);
    total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - ov0); end
    total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL ovr_data: got %h want 22", rx_data); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    rx_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept_clear: got %b want 0", rx_valid); end
    total++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h22) begin
      bad++; $display("FAIL ovr_accepted: got %0d bytes first=%h want 1 byte 22", got_n - n0, got_mem[n0[7:0]]);
    end
  endtask

  task automatic test_reset_mid;
    int n0, fe0, ov0;
    logic [7:0] d;
    n0 = got_n; fe0 = fe_cnt; ov0 = ov_cnt;
    d = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      bad++; $display("FAIL rstmid_outputs: got data=%h v=%b fe=%b ov=%b busy=%b want all 0", rx_data, rx_valid, frame_err, overrun, busy);
    end
    rst = 1'b0;
    repeat (BIT - HALF - 1) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(d[i]);
    if (NPAR != 0) drive_bit(par_of(d));
    drive_bit(1'b1);
    idle(BIT);
    total++; if (got_n !== n0 || fe_cnt !== fe0 || ov_cnt !== ov0) begin
      bad++; $display("FAIL rstmid_silent: got bytes=%0d fe=%0d ov=%0d want 0/0/0", got_n - n0, fe_cnt - fe0, ov_cnt - ov0);
    end
    send_frame(8'h0F, 1'b1, par_of(8'h0F));
    idle(BIT);
    total++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h0F) begin
      bad++; $display("FAIL rstmid_next_frame: got %0d bytes first=%h want 1 byte 0f", got_n - n0, got_mem[n0[7:0]]);
    end
  endtask

  task automatic test_back_to_back;
    int n0, fe0, ov0;
    logic [7:0] exp_q [$];
    logic [7:0] d;
    rx_ready = 1'b1;
    n0 = got_n; fe0 = fe_cnt; ov0 = ov_cnt;
    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1, par_of(d));
      idle($urandom_range(0, BIT));
    end
    idle(BIT);
    total++; if (got_n - n0 !== 20) begin bad++; $display("FAIL b2b_count: got %0d want 20", got_n - n0); end
    for (int k = 0; k < 20; k++) begin
      total++; if (got_mem[8'(n0 + k)] !== exp_q[k]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", k, got_mem[8'(n0 + k)], exp_q[k]);
      end
    end
    total++; if (fe_cnt !== fe0 || ov_cnt !== ov0) begin
      bad++; $display("FAIL b2b_errors: got fe=%0d ov=%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0, pe0;
    rx_ready = 1'b1;
    n0 = got_n; pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(BIT);
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_pulse: got %0d want 1", pe_cnt - pe0); end
    total++; if (got_n !== n0) begin bad++; $display("FAIL par_discard: got %0d bytes want 0", got_n - n0); end
    send_frame(8'h07, 1'b1, 1'b1);
    idle(BIT);
    total++; if (pe_cnt - pe0 !== 1) begin bad++; $display("FAIL par_no_pulse: got %0d want 1", pe_cnt - pe0); end
    total++; if (got_n - n0 !== 1 || got_mem[n0[7:0]] !== 8'h07) begin
      bad++; $display("FAIL par_good: got %0d bytes first=%h want 1 byte 07", got_n - n0, got_mem[n0[7:0]]);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
